// File: rtl/fb_arb_pkg.sv
// Shared definitions for the frame-buffer write arbiter: default widths,
// write-source encoding and the write-request payload.
package fb_arb_pkg;

  localparam int unsigned FB_ADDR_WIDTH = 17;
  localparam int unsigned FB_DATA_WIDTH = 12;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CAM  = 2'd1,
    SRC_SKID = 2'd2,
    SRC_CMD  = 2'd3
  } src_e;

  typedef struct packed {
    logic [FB_ADDR_WIDTH-1:0] addr;
    logic [FB_DATA_WIDTH-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/fb_wr_arbiter_cmd_wr_fifo.sv
// Small synchronous FIFO buffering command writes until the arbiter grants
// them a frame-buffer slot. Simultaneous push and pop is legal when full.
module cmd_wr_fifo #(
  parameter int unsigned WIDTH = 29,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_c,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty_c = (r_count == CNT_W'(0));
  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_head_c  = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Pop frees a slot in the same cycle, so a push into a full FIFO that is
  // also being popped is accepted.
  assign w_do_pop  = i_pop && !o_empty_c;
  assign w_do_push = i_push && (!o_full_c || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fb_wr_arbiter.sv
// Frame-buffer port-A write arbiter: camera has priority, command writes are
// queued and guaranteed a slot by a starvation guard with a camera skid entry.
module fb_wr_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = FB_DATA_WIDTH,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic                           clk,
  input  logic                           i_rst_n,
  input  logic                           i_cam_we,
  input  logic [ADDR_WIDTH-1:0]          i_cam_addr,
  input  logic [DATA_WIDTH-1:0]          i_cam_data,
  input  logic                           i_cmd_we,
  input  logic [ADDR_WIDTH-1:0]          i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]          i_cmd_data,
  input  logic                           i_clr_status,
  output logic                           o_mem_we,
  output logic [ADDR_WIDTH-1:0]          o_mem_addr,
  output logic [DATA_WIDTH-1:0]          o_mem_data,
  output logic [1:0]                     o_mem_src,
  output logic [$clog2(CMD_DEPTH):0]     o_cmd_count,
  output logic                           o_cmd_overflow
);

  localparam int unsigned CNT_W  = $clog2(CMD_DEPTH) + 1;
  localparam int unsigned REQ_W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

  // Registered arbiter state
  logic              r_skid_v;
  logic [REQ_W-1:0]  r_skid;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_overflow;
  logic              r_we;
  logic [REQ_W-1:0]  r_req;
  logic [1:0]        r_src;

  // Next-state / grant decode
  logic              w_skid_v_nxt;
  logic [REQ_W-1:0]  w_skid_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_overflow_nxt;
  logic              w_we_nxt;
  logic [REQ_W-1:0]  w_req_nxt;
  logic [1:0]        w_src_nxt;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [REQ_W-1:0]  w_cam_req;
  logic [REQ_W-1:0]  w_cmd_req;

  // FIFO interface
  logic [REQ_W-1:0]  w_fifo_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;

  assign w_cam_req = {i_cam_addr, i_cam_data};
  assign w_cmd_req = {i_cmd_addr, i_cmd_data};

  cmd_wr_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_push    (w_push),
    .i_data    (w_cmd_req),
    .i_pop     (w_pop),
    .o_head_c  (w_fifo_head),
    .o_full_c  (w_fifo_full),
    .o_empty_c (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  // Grant in priority order: skid, forced command, camera, command.
  always_comb begin
    w_we_nxt     = 1'b0;
    w_req_nxt    = '0;
    w_src_nxt    = SRC_NONE;
    w_pop        = 1'b0;
    w_skid_v_nxt = r_skid_v;
    w_skid_nxt   = r_skid;

    if (r_skid_v) begin
      w_we_nxt     = 1'b1;
      w_req_nxt    = r_skid;
      w_src_nxt    = SRC_SKID;
      w_skid_v_nxt = i_cam_we;
      w_skid_nxt   = w_cam_req;
    end else if (!w_fifo_empty && (r_wait_cnt == MAX_WAIT_V)) begin
      w_we_nxt  = 1'b1;
      w_req_nxt = w_fifo_head;
      w_src_nxt = SRC_CMD;
      w_pop     = 1'b1;
      if (i_cam_we) begin
        w_skid_v_nxt = 1'b1;
        w_skid_nxt   = w_cam_req;
      end
    end else if (i_cam_we) begin
      w_we_nxt  = 1'b1;
      w_req_nxt = w_cam_req;
      w_src_nxt = SRC_CAM;
    end else if (!w_fifo_empty) begin
      w_we_nxt  = 1'b1;
      w_req_nxt = w_fifo_head;
      w_src_nxt = SRC_CMD;
      w_pop     = 1'b1;
    end
  end

  // Starvation counter: tracks how long the FIFO head has been waiting.
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (w_pop || w_fifo_empty) begin
      w_wait_nxt = '0;
    end else if (r_wait_cnt != MAX_WAIT_V) begin
      w_wait_nxt = r_wait_cnt + WAIT_W'(1);
    end
  end

  // A drop wins over a same-cycle status clear.
  always_comb begin
    w_push         = i_cmd_we && (!w_fifo_full || w_pop);
    w_drop         = i_cmd_we && !w_push;
    w_overflow_nxt = r_overflow;
    if (w_drop) begin
      w_overflow_nxt = 1'b1;
    end else if (i_clr_status) begin
      w_overflow_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_skid_v   <= 1'b0;
      r_skid     <= '0;
      r_wait_cnt <= '0;
      r_overflow <= 1'b0;
      r_we       <= 1'b0;
      r_req      <= '0;
      r_src      <= SRC_NONE;
    end else begin
      r_skid_v   <= w_skid_v_nxt;
      r_skid     <= w_skid_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_overflow <= w_overflow_nxt;
      r_we       <= w_we_nxt;
      r_req      <= w_req_nxt;
      r_src      <= w_src_nxt;
    end
  end

  assign o_mem_we       = r_we;
  assign o_mem_addr     = r_req[REQ_W-1:DATA_WIDTH];
  assign o_mem_data     = r_req[DATA_WIDTH-1:0];
  assign o_mem_src      = r_src;
  assign o_cmd_count    = w_fifo_count;
  assign o_cmd_overflow = r_overflow;

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// Self-checking bench for fb_wr_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_fb_wr_arbiter;
  import fb_arb_pkg::*;

  localparam int AW    = 17;
  localparam int DW    = 12;
  localparam int DEPTH = 4;
  localparam int MAXW  = 8;

  logic          clk;
  logic          i_rst_n;
  logic          i_cam_we;
  logic [AW-1:0] i_cam_addr;
  logic [DW-1:0] i_cam_data;
  logic          i_cmd_we;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_data;
  logic          i_clr_status;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic [1:0]    o_mem_src;
  logic [2:0]    o_cmd_count;
  logic          o_cmd_overflow;

  fb_wr_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CMD_DEPTH  (DEPTH),
    .MAX_WAIT   (MAXW)
  ) dut (
    .clk            (clk),
    .i_rst_n        (i_rst_n),
    .i_cam_we       (i_cam_we),
    .i_cam_addr     (i_cam_addr),
    .i_cam_data     (i_cam_data),
    .i_cmd_we       (i_cmd_we),
    .i_cmd_addr     (i_cmd_addr),
    .i_cmd_data     (i_cmd_data),
    .i_clr_status   (i_clr_status),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_data     (o_mem_data),
    .o_mem_src      (o_mem_src),
    .o_cmd_count    (o_cmd_count),
    .o_cmd_overflow (o_cmd_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  wr_req_t m_cmd_q[$];
  wr_req_t m_skid_q[$];
  int      m_wait = 0;
  bit      m_ovf  = 1'b0;

  // Observation logs
  logic [AW-1:0] cam_seen[$];
  logic [1:0]    src_log[$];
  int            n_cmd_out = 0;
  int            n_we_out  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cmd_q.delete();
    m_skid_q.delete();
    m_wait = 0;
    m_ovf  = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input bit mw, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                      input bit clr);
    wr_req_t    cam_req;
    wr_req_t    cmd_req;
    wr_req_t    e_req;
    int         sz;
    bit         popped;
    bit         drop;
    bit         e_we;
    logic [1:0] e_src;
    cam_req = '{addr: ca, data: cd};
    cmd_req = '{addr: ma, data: md};
    i_cam_we     = cw;
    i_cam_addr   = ca;
    i_cam_data   = cd;
    i_cmd_we     = mw;
    i_cmd_addr   = ma;
    i_cmd_data   = md;
    i_clr_status = clr;

    sz     = m_cmd_q.size();
    popped = 1'b0;
    e_we   = 1'b0;
    e_src  = 2'd0;
    e_req  = '0;
    if (m_skid_q.size() != 0) begin
      e_we  = 1'b1;
      e_src = 2'd2;
      e_req = m_skid_q.pop_front();
      if (cw) m_skid_q.push_back(cam_req);
    end else if (sz != 0 && m_wait == MAXW) begin
      e_we   = 1'b1;
      e_src  = 2'd3;
      e_req  = m_cmd_q.pop_front();
      popped = 1'b1;
      if (cw) m_skid_q.push_back(cam_req);
    end else if (cw) begin
      e_we  = 1'b1;
      e_src = 2'd1;
      e_req = cam_req;
    end else if (sz != 0) begin
      e_we   = 1'b1;
      e_src  = 2'd3;
      e_req  = m_cmd_q.pop_front();
      popped = 1'b1;
    end
    m_wait = (popped || sz == 0) ? 0 : ((m_wait < MAXW) ? m_wait + 1 : MAXW);
    drop = mw && !(sz < DEPTH || popped);
    if (mw && !drop) m_cmd_q.push_back(cmd_req);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;

    @(posedge clk);
    #1;
    chk("we", 32'(o_mem_we), 32'(e_we));
    chk("src", 32'(o_mem_src), 32'(e_src));
    if (e_we) begin
      chk("addr", 32'(o_mem_addr), 32'(e_req.addr));
      chk("data", 32'(o_mem_data), 32'(e_req.data));
    end
    chk("count", 32'(o_cmd_count), 32'(m_cmd_q.size()));
    chk("ovf", 32'(o_cmd_overflow), 32'(m_ovf));

    src_log.push_back(o_mem_src);
    if (o_mem_we) n_we_out++;
    if (o_mem_we && (o_mem_src == 2'd1 || o_mem_src == 2'd2)) cam_seen.push_back(o_mem_addr);
    if (o_mem_we && o_mem_src == 2'd3) n_cmd_out++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int p;
    int bad;
    int reached;
    logic [1:0] skid_after;

    i_rst_n = 1'b0;
    i_cam_we = 1'b0; i_cam_addr = '0; i_cam_data = '0;
    i_cmd_we = 1'b0; i_cmd_addr = '0; i_cmd_data = '0;
    i_clr_status = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_we", 32'(o_mem_we), 32'd0);
    chk("rst_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_data", 32'(o_mem_data), 32'd0);
    chk("rst_src", 32'(o_mem_src), 32'd0);
    chk("rst_count", 32'(o_cmd_count), 32'd0);
    chk("rst_ovf", 32'(o_cmd_overflow), 32'd0);
    i_rst_n = 1'b1;
    model_reset();
    idle(3);

    // Single command: issued two cycles after its pulse
    step(1'b0, '0, '0, 1'b1, AW'(1234), DW'(12'hABC), 1'b0);
    chk("t1_we_early", 32'(o_mem_we), 32'd0);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    chk("t1_we", 32'(o_mem_we), 32'd1);
    chk("t1_addr", 32'(o_mem_addr), 32'd1234);
    chk("t1_data", 32'(o_mem_data), 32'hABC);
    chk("t1_src", 32'(o_mem_src), 32'd3);
    idle(1);
    chk("t1_count", 32'(o_cmd_count), 32'd0);

    // Camera every other cycle, 3 commands interleaved
    cam_seen.delete();
    n_cmd_out = 0;
    for (int i = 0; i < 200; i++) begin
      step((i % 2) == 0, AW'(i / 2), DW'($urandom), (i == 3 || i == 40 || i == 41),
           AW'(5000 + i), DW'(i), 1'b0);
    end
    idle(4);
    chk("t2_cam_n", 32'(cam_seen.size()), 32'd100);
    bad = 0;
    for (int k = 0; k < cam_seen.size(); k++) if (cam_seen[k] != AW'(k)) bad++;
    chk("t2_order", 32'(bad), 32'd0);
    chk("t2_cmd_n", 32'(n_cmd_out), 32'd3);
    chk("t2_ovf", 32'(o_cmd_overflow), 32'd0);

    // Continuous camera, one pending command forced at wait_cnt == MAX_WAIT
    cam_seen.delete();
    src_log.delete();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, AW'(200 + i), DW'(i), (i == 0), AW'(777), DW'(12'h123), 1'b0);
    end
    idle(3);
    p = -1;
    for (int k = 0; k < src_log.size(); k++) if (src_log[k] == 2'd3 && p < 0) p = k;
    chk("t3_cmd_slot", 32'(p), 32'(MAXW + 1));
    skid_after = (p >= 0 && p + 1 < src_log.size()) ? src_log[p + 1] : 2'd0;
    chk("t3_skid_next", 32'(skid_after), 32'd2);
    chk("t3_cam_n", 32'(cam_seen.size()), 32'd20);
    bad = 0;
    for (int k = 0; k < cam_seen.size(); k++) if (cam_seen[k] != AW'(200 + k)) bad++;
    chk("t3_order", 32'(bad), 32'd0);

    // Six back-to-back commands under continuous camera: fifth overflows
    for (int i = 0; i < 6; i++) begin
      step(1'b1, AW'(300 + i), DW'(i), 1'b1, AW'(900 + i), DW'(i), 1'b0);
      if (i == 3) chk("t4_ovf_pre", 32'(o_cmd_overflow), 32'd0);
      if (i == 4) chk("t4_ovf_set", 32'(o_cmd_overflow), 32'd1);
    end
    chk("t4_count", 32'(o_cmd_count), 32'd4);
    step(1'b1, AW'(306), '0, 1'b0, '0, '0, 1'b1);
    chk("t4_ovf_clr", 32'(o_cmd_overflow), 32'd0);

    // Push into a full FIFO on the same cycle it pops
    step(1'b0, '0, '0, 1'b1, AW'(999), DW'(12'h999), 1'b0);
    chk("t5_count", 32'(o_cmd_count), 32'd4);
    chk("t5_ovf", 32'(o_cmd_overflow), 32'd0);
    chk("t5_src", 32'(o_mem_src), 32'd3);
    idle(10);
    chk("t5_drained", 32'(o_cmd_count), 32'd0);

    // Reset mid-operation with skid valid and two commands queued
    reached = 0;
    for (int i = 0; i < 40 && reached == 0; i++) begin
      step(1'b1, AW'(400 + i), DW'(i), (i < 3), AW'(1000 + i), DW'(i), 1'b0);
      if (m_skid_q.size() == 1 && m_cmd_q.size() >= 2) reached = 1;
    end
    chk("t6_reached", 32'(reached), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t6_we", 32'(o_mem_we), 32'd0);
    chk("t6_src", 32'(o_mem_src), 32'd0);
    chk("t6_count", 32'(o_cmd_count), 32'd0);
    i_cam_we = 1'b0;
    i_cmd_we = 1'b0;
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    model_reset();
    n_we_out = 0;
    idle(6);
    chk("t6_no_stale", 32'(n_we_out), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 7, AW'($urandom), DW'($urandom),
           $urandom_range(0, 3) == 0, AW'($urandom), DW'($urandom),
           $urandom_range(0, 19) == 0);
    end
    idle(20);
    chk("rnd_empty", 32'(o_cmd_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
